// File: rtl/iir_pkg.sv
// iir_pkg
// Shared definitions for the IIR coefficient controller slice: default
// word geometry, the coefficient word type, the controller state encoding,
// the coefficient address map and a helper that maps (section, tap) to a
// word address.
//
// Address map (default geometry, N = 8 -> 4 sections, 16 words):
//   0 .. 3*NS-1     SOS words, section s tap k at 3*s+k, taps {b1,a1,a2}
//   3*NS .. 4*NS-1  per-section gain words G[s]
package iir_pkg;

    localparam int DEF_WIDTH_H = 15;
    localparam int DEF_WIDTH_W = 10;
    localparam int DEF_N       = 8;
    localparam int DEF_TIMEOUT = 64;

    localparam int COEF_WD = DEF_WIDTH_H + DEF_WIDTH_W;
    localparam int DEF_NS  = DEF_N / 2;
    localparam int DEF_NW  = 4 * DEF_NS;

    localparam int SOS_BASE = 0;
    localparam int G_BASE   = 3 * DEF_NS;

    typedef logic [COEF_WD-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        STALL,
        SWAP
    } ctrl_state_e;

    // Default coefficients make every section a pass-through: zero feedback
    // and feed-forward taps with unity (1.0 in Q format) gain.
    localparam coef_t UNITY = coef_t'(1) << DEF_WIDTH_W;
    localparam logic [3*DEF_NS*COEF_WD-1:0] SOS_INIT_DEF = '0;
    localparam logic [DEF_NS*COEF_WD-1:0]   G_INIT_DEF   = {DEF_NS{UNITY}};

    function automatic int sec_addr(input int s, input int k);
        return SOS_BASE + 3 * s + k;
    endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// iir_coef_bank
// NW-word coefficient register file with one write port, one registered
// read port and a parallel flat load used to copy a whole bank in one cycle.
// Ports:
//   clk, rst           clock, synchronous active-high reset (loads INIT)
//   wr_en/wr_addr/wr_data   single-word write, ignored for addr >= NW
//   rd_en/rd_addr      read request; rd_data valid the next cycle
//   rd_data            registered read data, 0 for addr >= NW, holds otherwise
//   load_en/load_data  load all words at once (priority over the write port)
//   words_o            current contents, flat, word 0 at the LSBs
module iir_coef_bank #(
    parameter int              WD   = 25,
    parameter int              NW   = 16,
    parameter int              AW   = 4,
    parameter logic [NW*WD-1:0] INIT = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WD-1:0]      wr_data,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    output logic [WD-1:0]      rd_data,
    input  logic               load_en,
    input  logic [NW*WD-1:0]   load_data,
    output logic [NW*WD-1:0]   words_o
);

    logic [WD-1:0] mem [NW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) begin
                mem[i] <= INIT[i*WD +: WD];
            end
        end else if (load_en) begin
            for (int i = 0; i < NW; i++) begin
                mem[i] <= load_data[i*WD +: WD];
            end
        end else if (wr_en && (int'(wr_addr) < NW)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read samples mem before this edge's write, so a same-address
    // read/write returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (int'(rd_addr) < NW) ? mem[rd_addr] : '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NW; i++) begin
            words_o[i*WD +: WD] = mem[i];
        end
    end

endmodule

// File: rtl/iir_coef_ctrl.sv
// iir_coef_ctrl
// Run-time coefficient controller for a biquad-cascade IIR core. The host
// writes SOS/G words into a shadow bank; a commit request swaps the whole
// shadow bank into the active bank at a sample boundary (a cycle with
// data_i_en low) and pulses state_clr_o so the core restarts from clean
// delay registers. If no boundary appears within TIMEOUT sample cycles, the
// controller stalls upstream for one cycle to make one.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_wr_en/addr/data      shadow write (accepted in IDLE only)
//   cfg_rd_en                shadow read; cfg_rd_data/cfg_rd_valid next cycle
//   cfg_commit               request shadow->active swap
//   cfg_busy                 swap in progress; writes/commits ignored
//   cfg_err, cfg_err_clr     sticky error flag and its clear
//   data_i_en                snooped sample strobe of the IIR core
//   stall_o                  upstream must hold its next sample
//   coef_sos_o, coef_g_o     active banks, flat, word 0 at the LSBs
//   state_clr_o              one-cycle clear pulse for the core's state
//   swap_cnt_o               completed swaps, wraps
module iir_coef_ctrl
    import iir_pkg::*;
#(
    parameter int width_H = DEF_WIDTH_H,
    parameter int width_W = DEF_WIDTH_W,
    parameter int N       = DEF_N,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter logic [3*(N/2)*(width_H+width_W)-1:0] SOS_INIT = SOS_INIT_DEF,
    parameter logic [(N/2)*(width_H+width_W)-1:0]   G_INIT   = G_INIT_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_wr_en,
    input  logic                                  cfg_rd_en,
    input  logic [$clog2(4*(N/2))-1:0]            cfg_addr,
    input  logic [width_H+width_W-1:0]            cfg_data,
    input  logic                                  cfg_commit,
    output logic [width_H+width_W-1:0]            cfg_rd_data,
    output logic                                  cfg_rd_valid,
    output logic                                  cfg_busy,
    output logic                                  cfg_err,
    input  logic                                  cfg_err_clr,
    input  logic                                  data_i_en,
    output logic                                  stall_o,
    output logic [3*(N/2)*(width_H+width_W)-1:0]  coef_sos_o,
    output logic [(N/2)*(width_H+width_W)-1:0]    coef_g_o,
    output logic                                  state_clr_o,
    output logic [15:0]                           swap_cnt_o
);

    localparam int WD = width_H + width_W;
    localparam int NS = N / 2;
    localparam int NW = 4 * NS;
    localparam int AW = $clog2(NW);
    localparam int TW = $clog2(TIMEOUT + 1);

    ctrl_state_e       state, state_next;
    logic [TW-1:0]     timer;
    logic              addr_ok;
    logic              wr_accept;
    logic              commit_accept;
    logic              err_set;
    logic [NW*WD-1:0]  shadow_words;

    assign addr_ok       = (int'(cfg_addr) < NW);
    assign wr_accept     = cfg_wr_en && (state == IDLE) && addr_ok;
    assign commit_accept = cfg_commit && (state == IDLE);

    // Shadow bank: G words sit above the SOS words, so its reset image is
    // simply the two INIT vectors concatenated.
    iir_coef_bank #(
        .WD   (WD),
        .NW   (NW),
        .AW   (AW),
        .INIT ({G_INIT, SOS_INIT})
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_accept),
        .wr_addr   (cfg_addr),
        .wr_data   (cfg_data),
        .rd_en     (cfg_rd_en),
        .rd_addr   (cfg_addr),
        .rd_data   (cfg_rd_data),
        .load_en   (1'b0),
        .load_data ('0),
        .words_o   (shadow_words)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (commit_accept) state_next = PENDING;
            PENDING: begin
                if (!data_i_en) begin
                    state_next = SWAP;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_next = STALL;
                end
            end
            STALL:   state_next = SWAP;
            SWAP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cfg_busy    = (state != IDLE);
        stall_o     = (state == STALL);
        state_clr_o = (state == SWAP);
    end

    // The wait timer only advances on cycles that actually carry a sample,
    // so TIMEOUT counts missed boundaries rather than raw clock cycles.
    always_ff @(posedge clk) begin
        if (rst || (state != PENDING)) begin
            timer <= '0;
        end else if (data_i_en) begin
            timer <= timer + TW'(1);
        end
    end

    // The whole active bank is replaced in one edge so the core never sees
    // a mix of old and new coefficients.
    always_ff @(posedge clk) begin
        if (rst) begin
            coef_sos_o <= SOS_INIT;
            coef_g_o   <= G_INIT;
            swap_cnt_o <= '0;
        end else if (state == SWAP) begin
            coef_sos_o <= shadow_words[3*NS*WD-1:0];
            coef_g_o   <= shadow_words[NW*WD-1:3*NS*WD];
            swap_cnt_o <= swap_cnt_o + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rd_valid <= 1'b0;
        end else begin
            cfg_rd_valid <= cfg_rd_en;
        end
    end

    // A new error in the same cycle as a clear keeps the flag set.
    assign err_set = ((cfg_wr_en || cfg_rd_en) && !addr_ok)
                   || ((cfg_wr_en || cfg_commit) && cfg_busy)
                   || ((state == STALL) && data_i_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else if (err_set) begin
            cfg_err <= 1'b1;
        end else if (cfg_err_clr) begin
            cfg_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// tb_iir_coef_ctrl
// Directed bench for iir_coef_ctrl at N = 8 (16 words, 4-bit address).
// A table of single-cycle vectors covers writes, reads, read-during-write,
// commit at a free boundary, writes/commits while busy and error clearing.
// Hand-written sequences cover the timeout stall, a sample in STALL, and
// reset in the middle of a pending swap.
module tb_iir_coef_ctrl;

    localparam int WIDTH_H = 15;
    localparam int WIDTH_W = 10;
    localparam int N       = 8;
    localparam int TIMEOUT = 64;
    localparam int WD      = WIDTH_H + WIDTH_W;
    localparam int NS      = N / 2;
    localparam int AW      = 4;
    localparam int CW      = 400;

    function automatic logic [WD-1:0] sos_word(input int i);
        int v;
        v = i * 4097 + 3;
        if (i % 2 == 1) v = -v;
        return WD'(v);
    endfunction

    function automatic logic [WD-1:0] g_word(input int s);
        return WD'(1024 + s * 100);
    endfunction

    function automatic logic [3*NS*WD-1:0] build_sos();
        logic [3*NS*WD-1:0] f;
        f = '0;
        for (int i = 0; i < 3 * NS; i++) f[i*WD +: WD] = sos_word(i);
        return f;
    endfunction

    function automatic logic [NS*WD-1:0] build_g();
        logic [NS*WD-1:0] f;
        f = '0;
        for (int s = 0; s < NS; s++) f[s*WD +: WD] = g_word(s);
        return f;
    endfunction

    localparam logic [3*NS*WD-1:0] SOS_INIT_P = build_sos();
    localparam logic [NS*WD-1:0]   G_INIT_P   = build_g();

    logic              clk;
    logic              rst;
    logic              cfg_wr_en;
    logic              cfg_rd_en;
    logic [AW-1:0]     cfg_addr;
    logic [WD-1:0]     cfg_data;
    logic              cfg_commit;
    logic [WD-1:0]     cfg_rd_data;
    logic              cfg_rd_valid;
    logic              cfg_busy;
    logic              cfg_err;
    logic              cfg_err_clr;
    logic              data_i_en;
    logic              stall_o;
    logic [3*NS*WD-1:0] coef_sos_o;
    logic [NS*WD-1:0]  coef_g_o;
    logic              state_clr_o;
    logic [15:0]       swap_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    iir_coef_ctrl #(
        .width_H  (WIDTH_H),
        .width_W  (WIDTH_W),
        .N        (N),
        .TIMEOUT  (TIMEOUT),
        .SOS_INIT (SOS_INIT_P),
        .G_INIT   (G_INIT_P)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_rd_en    (cfg_rd_en),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_commit   (cfg_commit),
        .cfg_rd_data  (cfg_rd_data),
        .cfg_rd_valid (cfg_rd_valid),
        .cfg_busy     (cfg_busy),
        .cfg_err      (cfg_err),
        .cfg_err_clr  (cfg_err_clr),
        .data_i_en    (data_i_en),
        .stall_o      (stall_o),
        .coef_sos_o   (coef_sos_o),
        .coef_g_o     (coef_g_o),
        .state_clr_o  (state_clr_o),
        .swap_cnt_o   (swap_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [AW-1:0] addr;
        logic [WD-1:0] data;
        logic          commit;
        logic          err_clr;
        logic          den;
        logic          e_valid;
        logic [WD-1:0] e_rd;
        logic          e_busy;
        logic          e_err;
        logic          e_stall;
        logic          e_clr;
        logic [15:0]   e_cnt;
        logic [WD-1:0] e_g0;
    } vec_t;

    function automatic vec_t mkv(input int wr, input int rd, input int addr,
                                 input int data, input int commit,
                                 input int err_clr, input int den,
                                 input int e_valid, input int e_rd,
                                 input int e_busy, input int e_err,
                                 input int e_stall, input int e_clr,
                                 input int e_cnt, input int e_g0);
        vec_t v;
        v.wr      = wr[0];
        v.rd      = rd[0];
        v.addr    = AW'(addr);
        v.data    = WD'(data);
        v.commit  = commit[0];
        v.err_clr = err_clr[0];
        v.den     = den[0];
        v.e_valid = e_valid[0];
        v.e_rd    = WD'(e_rd);
        v.e_busy  = e_busy[0];
        v.e_err   = e_err[0];
        v.e_stall = e_stall[0];
        v.e_clr   = e_clr[0];
        v.e_cnt   = 16'(e_cnt);
        v.e_g0    = WD'(e_g0);
        return v;
    endfunction

    // Drive one cycle of inputs away from the edge, then sample #1 after it.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        cfg_wr_en   = v.wr;
        cfg_rd_en   = v.rd;
        cfg_addr    = v.addr;
        cfg_data    = v.data;
        cfg_commit  = v.commit;
        cfg_err_clr = v.err_clr;
        data_i_en   = v.den;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [CW-1:0] act,
                               input logic [CW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkRow(input int r, input vec_t v);
        checkOutput($sformatf("row%0d rd_valid", r), CW'(cfg_rd_valid), CW'(v.e_valid));
        checkOutput($sformatf("row%0d rd_data", r), CW'(cfg_rd_data), CW'(v.e_rd));
        checkOutput($sformatf("row%0d busy", r), CW'(cfg_busy), CW'(v.e_busy));
        checkOutput($sformatf("row%0d err", r), CW'(cfg_err), CW'(v.e_err));
        checkOutput($sformatf("row%0d stall", r), CW'(stall_o), CW'(v.e_stall));
        checkOutput($sformatf("row%0d state_clr", r), CW'(state_clr_o), CW'(v.e_clr));
        checkOutput($sformatf("row%0d swap_cnt", r), CW'(swap_cnt_o), CW'(v.e_cnt));
        checkOutput($sformatf("row%0d g0", r), CW'(coef_g_o[WD-1:0]), CW'(v.e_g0));
    endtask

    // Drive data_i_en each cycle until stall_o rises; returns the number of
    // edges taken, or -1 if the bound expires.
    task automatic waitStall(input logic den_level, output int edges);
        edges = -1;
        for (int i = 1; i <= 200; i++) begin
            applyStimulus(mkv(0, 0, 0, 0, 0, 0, den_level, 0, 0, 0, 0, 0, 0, 0, 0));
            if (stall_o) begin
                edges = i;
                break;
            end
        end
    endtask

    vec_t vecs[17];
    vec_t idle_v;
    int   edges;
    int   clr_seen;
    int   g0i;
    int   s5;

    initial begin
        rst         = 1'b1;
        cfg_wr_en   = 1'b0;
        cfg_rd_en   = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;
        cfg_commit  = 1'b0;
        cfg_err_clr = 1'b0;
        data_i_en   = 1'b0;
        idle_v      = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        g0i         = int'(g_word(0));
        s5          = int'(sos_word(5));

        //             wr rd adr data  cm ec de | val rd     bsy err stl clr cnt g0
        vecs[0]  = mkv(0, 0, 0,  0,     0, 0, 0,  0, 0,     0, 0, 0, 0, 0, g0i);
        vecs[1]  = mkv(1, 0, 12, 28745, 0, 0, 0,  0, 0,     0, 0, 0, 0, 0, g0i);
        vecs[2]  = mkv(0, 1, 12, 0,     0, 0, 0,  1, 28745, 0, 0, 0, 0, 0, g0i);
        vecs[3]  = mkv(1, 1, 12, 12345, 0, 0, 0,  1, 28745, 0, 0, 0, 0, 0, g0i);
        vecs[4]  = mkv(0, 1, 12, 0,     0, 0, 0,  1, 12345, 0, 0, 0, 0, 0, g0i);
        vecs[5]  = mkv(0, 1, 0,  0,     0, 0, 0,  1, 3,     0, 0, 0, 0, 0, g0i);
        vecs[6]  = mkv(1, 0, 12, 28745, 1, 0, 0,  0, 3,     1, 0, 0, 0, 0, g0i);
        vecs[7]  = mkv(0, 0, 0,  0,     0, 0, 0,  0, 3,     1, 0, 0, 1, 0, g0i);
        vecs[8]  = mkv(0, 0, 0,  0,     0, 0, 0,  0, 3,     0, 0, 0, 0, 1, 28745);
        vecs[9]  = mkv(0, 1, 12, 0,     0, 0, 0,  1, 28745, 0, 0, 0, 0, 1, 28745);
        vecs[10] = mkv(0, 0, 0,  0,     1, 0, 1,  0, 28745, 1, 0, 0, 0, 1, 28745);
        vecs[11] = mkv(1, 0, 5,  777,   0, 0, 1,  0, 28745, 1, 1, 0, 0, 1, 28745);
        vecs[12] = mkv(0, 1, 5,  0,     0, 0, 0,  1, s5,    1, 1, 0, 1, 1, 28745);
        vecs[13] = mkv(0, 0, 0,  0,     1, 1, 0,  0, s5,    0, 1, 0, 0, 2, 28745);
        vecs[14] = mkv(0, 0, 0,  0,     0, 1, 0,  0, s5,    0, 0, 0, 0, 2, 28745);
        vecs[15] = mkv(0, 0, 0,  0,     0, 0, 0,  0, s5,    0, 0, 0, 0, 2, 28745);
        vecs[16] = mkv(0, 1, 12, 0,     0, 0, 0,  1, 28745, 0, 0, 0, 0, 2, 28745);

        // Reset held for two cycles.
        applyStimulus(idle_v);
        applyStimulus(idle_v);
        checkOutput("reset sos", CW'(coef_sos_o), CW'(SOS_INIT_P));
        checkOutput("reset g", CW'(coef_g_o), CW'(G_INIT_P));
        checkOutput("reset swap_cnt", CW'(swap_cnt_o), CW'(0));
        checkOutput("reset strobes",
                    CW'({cfg_rd_valid, cfg_busy, cfg_err, stall_o, state_clr_o}), CW'(0));
        checkOutput("reset rd_data", CW'(cfg_rd_data), CW'(0));
        rst = 1'b0;

        for (int r = 0; r < 17; r++) begin
            applyStimulus(vecs[r]);
            checkRow(r, vecs[r]);
        end

        // Timeout: samples keep coming, so the controller must force a stall.
        applyStimulus(mkv(1, 0, 13, 4242, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mkv(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("timeout busy after commit", CW'(cfg_busy), CW'(1));
        waitStall(1'b1, edges);
        checkOutput("timeout stall latency", CW'(edges), CW'(TIMEOUT));
        applyStimulus(idle_v);
        checkOutput("timeout swap clr", CW'(state_clr_o), CW'(1));
        checkOutput("timeout swap stall low", CW'(stall_o), CW'(0));
        checkOutput("timeout active g before", CW'(coef_g_o[WD +: WD]), CW'(g_word(1)));
        applyStimulus(idle_v);
        checkOutput("timeout active g1", CW'(coef_g_o[WD +: WD]), CW'(4242));
        checkOutput("timeout swap_cnt", CW'(swap_cnt_o), CW'(3));
        checkOutput("timeout no err", CW'(cfg_err), CW'(0));
        checkOutput("timeout idle", CW'(cfg_busy), CW'(0));

        // A sample arriving during STALL: swap still happens, error flagged.
        applyStimulus(mkv(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        waitStall(1'b1, edges);
        checkOutput("stall2 latency", CW'(edges), CW'(TIMEOUT));
        applyStimulus(mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("stall2 sample err", CW'(cfg_err), CW'(1));
        checkOutput("stall2 swap clr", CW'(state_clr_o), CW'(1));
        applyStimulus(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("stall2 swap_cnt", CW'(swap_cnt_o), CW'(4));
        checkOutput("stall2 err cleared", CW'(cfg_err), CW'(0));

        // Reset in the middle of PENDING aborts the swap.
        applyStimulus(mkv(1, 0, 14, 9999, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(mkv(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        clr_seen = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            clr_seen += int'(state_clr_o);
        end
        checkOutput("pending before reset", CW'(cfg_busy), CW'(1));
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(idle_v);
            clr_seen += int'(state_clr_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(idle_v);
            clr_seen += int'(state_clr_o);
        end
        checkOutput("midreset busy", CW'(cfg_busy), CW'(0));
        checkOutput("midreset no clr pulse", CW'(clr_seen), CW'(0));
        checkOutput("midreset swap_cnt", CW'(swap_cnt_o), CW'(0));
        checkOutput("midreset sos", CW'(coef_sos_o), CW'(SOS_INIT_P));
        checkOutput("midreset g", CW'(coef_g_o), CW'(G_INIT_P));
        applyStimulus(mkv(0, 1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        checkOutput("midreset shadow g2", CW'(cfg_rd_data), CW'(g_word(2)));
        checkOutput("midreset rd_valid", CW'(cfg_rd_valid), CW'(1));

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
